// File: rtl/axis_bdim_block_arbiter.sv
// Block-granular round-robin arbiter. N_INPUTS AXI-Stream lanes share one
// output stream. A grant is held for exactly OUTPUT0_BDIM accepted beats, so
// a block from one lane is never interleaved with another lane's data.
//
// state | meaning
// IDLE  | no grant held; choose next requester round-robin from pointer+1
// XFER  | grant held; granted lane passed through until BDIM beats accepted
module axis_bdim_block_arbiter #(
  parameter int N_INPUTS     = 4,
  parameter int DATA_WIDTH   = 8,
  parameter int OUTPUT0_BDIM = 8,
  parameter int CNT_WIDTH    = 16,
  localparam int TID_W  = (N_INPUTS > 1) ? $clog2(N_INPUTS) : 1,
  localparam int BEAT_W = (OUTPUT0_BDIM > 1) ? $clog2(OUTPUT0_BDIM) : 1
) (
  input  logic                           ap_clk,
  input  logic                           ap_rst_n,
  input  logic [N_INPUTS*DATA_WIDTH-1:0] s_axis_tdata,
  input  logic [N_INPUTS-1:0]            s_axis_tvalid,
  output logic [N_INPUTS-1:0]            s_axis_tready,
  output logic [DATA_WIDTH-1:0]          m_axis_output0_tdata,
  output logic                           m_axis_output0_tvalid,
  input  logic                           m_axis_output0_tready,
  output logic                           m_axis_output0_tlast,
  output logic [TID_W-1:0]               m_axis_output0_tid,
  output logic                           busy,
  output logic [CNT_WIDTH-1:0]           blocks_done
);

  typedef enum logic {IDLE = 1'b0, XFER = 1'b1} state_t;

  state_t             state_q;
  state_t             state_d;
  logic [TID_W-1:0]   grant_q;
  logic [TID_W-1:0]   ptr_q;
  logic [BEAT_W-1:0]  beat_q;
  logic [CNT_WIDTH-1:0] blocks_q;
  logic [TID_W-1:0]   sel;
  logic               req_any;
  logic               hs;
  int                 idx;

  assign hs          = m_axis_output0_tvalid & m_axis_output0_tready;
  assign blocks_done = blocks_q;

  // State register.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Round-robin pick: first requesting lane at or after pointer+1, wrapping.
  always_comb begin
    sel     = ptr_q;
    req_any = 1'b0;
    idx     = 0;
    for (int k = 1; k <= N_INPUTS; k++) begin
      idx = (int'(ptr_q) + k) % N_INPUTS;
      if (!req_any && s_axis_tvalid[idx]) begin
        sel     = TID_W'(idx);
        req_any = 1'b1;
      end
    end
  end

  // Next-state: leave IDLE on any request, leave XFER on the last accepted beat.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (req_any) state_d = XFER;
      XFER:    if (hs && m_axis_output0_tlast) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs: quiet in IDLE, combinational passthrough of the granted lane in XFER.
  always_comb begin
    m_axis_output0_tdata  = '0;
    m_axis_output0_tvalid = 1'b0;
    m_axis_output0_tlast  = 1'b0;
    m_axis_output0_tid    = '0;
    s_axis_tready         = '0;
    busy                  = 1'b0;
    if (state_q == XFER) begin
      m_axis_output0_tdata   = s_axis_tdata[int'(grant_q)*DATA_WIDTH +: DATA_WIDTH];
      m_axis_output0_tvalid  = s_axis_tvalid[grant_q];
      m_axis_output0_tlast   = (beat_q == BEAT_W'(OUTPUT0_BDIM - 1));
      m_axis_output0_tid     = grant_q;
      s_axis_tready[grant_q] = m_axis_output0_tready;
      busy                   = 1'b1;
    end
  end

  // Grant/pointer capture, beat counting and completed-block count.
  // The pointer resets to the last lane so lane 0 wins the first round.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      grant_q  <= '0;
      ptr_q    <= TID_W'(N_INPUTS - 1);
      beat_q   <= '0;
      blocks_q <= '0;
    end else begin
      if (state_q == IDLE && req_any) begin
        grant_q <= sel;
        ptr_q   <= sel;
      end
      if (hs) begin
        if (m_axis_output0_tlast) begin
          beat_q   <= '0;
          blocks_q <= blocks_q + CNT_WIDTH'(1);
        end else begin
          beat_q <= beat_q + BEAT_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_axis_bdim_block_arbiter.sv
// Bench for axis_bdim_block_arbiter: lane source models feed the DUT, expected
// beats are queued when stimulus is issued and a monitor compares each
// accepted output beat. A second instance covers the BDIM=1 build.
module tb_axis_bdim_block_arbiter;
  localparam int N  = 4;
  localparam int DW = 8;

  logic              ap_clk = 1'b0;
  logic              ap_rst_n;
  logic [N*DW-1:0]   s_tdata;
  logic [N-1:0]      s_tvalid;
  logic [N-1:0]      s_tready;
  logic [DW-1:0]     m_tdata;
  logic              m_tvalid;
  logic              m_tready;
  logic              m_tlast;
  logic [1:0]        m_tid;
  logic              busy;
  logic [15:0]       blocks_done;

  logic              b_rst_n;
  logic [N*DW-1:0]   b_tdata;
  logic [N-1:0]      b_tvalid;
  logic [N-1:0]      b_tready;
  logic [DW-1:0]     b_m_tdata;
  logic              b_m_tvalid;
  logic              b_m_tready;
  logic              b_m_tlast;
  logic [1:0]        b_m_tid;
  logic              b_busy;
  logic [3:0]        b_blocks;

  int                n_vec = 0;
  int                n_err = 0;
  logic [7:0]        lq [N][$];
  logic [N-1:0]      lane_en;
  logic              rnd_rdy;
  logic [N-1:0]      acc;
  logic [7:0]        junk;
  logic [10:0]       sb [$];
  logic [10:0]       sb_b [$];
  logic [10:0]       exp_main;
  logic [10:0]       exp_b;
  logic [3:0]        b_cnt = 4'd0;

  always #5 ap_clk = ~ap_clk;

  axis_bdim_block_arbiter #(
    .N_INPUTS(N), .DATA_WIDTH(DW), .OUTPUT0_BDIM(8), .CNT_WIDTH(16)
  ) u_dut (
    .ap_clk(ap_clk), .ap_rst_n(ap_rst_n),
    .s_axis_tdata(s_tdata), .s_axis_tvalid(s_tvalid), .s_axis_tready(s_tready),
    .m_axis_output0_tdata(m_tdata), .m_axis_output0_tvalid(m_tvalid),
    .m_axis_output0_tready(m_tready), .m_axis_output0_tlast(m_tlast),
    .m_axis_output0_tid(m_tid), .busy(busy), .blocks_done(blocks_done)
  );

  axis_bdim_block_arbiter #(
    .N_INPUTS(N), .DATA_WIDTH(DW), .OUTPUT0_BDIM(1), .CNT_WIDTH(4)
  ) u_dut_b1 (
    .ap_clk(ap_clk), .ap_rst_n(b_rst_n),
    .s_axis_tdata(b_tdata), .s_axis_tvalid(b_tvalid), .s_axis_tready(b_tready),
    .m_axis_output0_tdata(b_m_tdata), .m_axis_output0_tvalid(b_m_tvalid),
    .m_axis_output0_tready(b_m_tready), .m_axis_output0_tlast(b_m_tlast),
    .m_axis_output0_tid(b_m_tid), .busy(b_busy), .blocks_done(b_blocks)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_vec++;
    if (act !== expv) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, expv, $time);
    end
  endtask

  task automatic drive();
    for (int i = 0; i < N; i++) begin
      s_tvalid[i] = lane_en[i] && (lq[i].size() != 0);
      s_tdata[i*DW +: DW] = (lq[i].size() != 0) ? lq[i][0] : 8'h00;
    end
  endtask

  task automatic load(input int lane, input logic [7:0] base, input int n);
    for (int j = 0; j < n; j++) lq[lane].push_back(base + 8'(j));
  endtask

  // Expected beats {tid, data, last}; last on every 8th beat of a block.
  task automatic exp_blk(input int lane, input logic [7:0] base, input int n);
    logic [1:0] t;
    logic [7:0] d;
    logic       l;
    for (int j = 0; j < n; j++) begin
      t = 2'(lane);
      d = base + 8'(j);
      l = ((j % 8) == 7);
      sb.push_back({t, d, l});
    end
  endtask

  task automatic do_reset();
    @(negedge ap_clk);
    ap_rst_n = 1'b0;
    for (int i = 0; i < N; i++) lq[i].delete();
    lane_en = '1;
    rnd_rdy = 1'b0;
    repeat (2) @(negedge ap_clk);
    ap_rst_n = 1'b1;
  endtask

  task automatic wait_valid(input int limit);
    int k;
    k = 0;
    do begin
      @(negedge ap_clk); #1;
      k++;
    end while (!m_tvalid && k < limit);
    check("grant_seen", 32'(m_tvalid), 32'd1);
  endtask

  task automatic wait_blocks(input int n, input int limit);
    int k;
    k = 0;
    while (blocks_done != 16'(n) && k < limit) begin
      @(negedge ap_clk); #1;
      k++;
    end
    check("blocks_done", 32'(blocks_done), 32'(n));
  endtask

  // Lane sources: a beat leaves its queue only when it was handshaken.
  initial begin
    s_tvalid = '0;
    s_tdata  = '0;
    m_tready = 1'b1;
    lane_en  = '1;
    rnd_rdy  = 1'b0;
    forever begin
      @(negedge ap_clk);
      acc = s_tvalid & s_tready;
      @(posedge ap_clk); #1;
      for (int i = 0; i < N; i++)
        if (acc[i] && lq[i].size() != 0) junk = lq[i].pop_front();
      m_tready = rnd_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
      drive();
    end
  end

  // Main monitor.
  initial forever begin
    @(negedge ap_clk);
    if (ap_rst_n && m_tvalid && m_tready) begin
      if (sb.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_beat: got tid=%0d data=0x%02h, expected no beat", m_tid, m_tdata);
      end else begin
        exp_main = sb.pop_front();
        check("beat", 32'({m_tid, m_tdata, m_tlast}), 32'(exp_main));
      end
    end
  end

  // BDIM=1 monitor: every beat is a block, blocks_done counts beats mod 16.
  initial forever begin
    @(negedge ap_clk);
    if (b_rst_n && b_m_tvalid && b_m_tready) begin
      if (sb_b.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL b1_unexpected_beat: got tid=%0d, expected no beat", b_m_tid);
      end else begin
        exp_b = sb_b.pop_front();
        check("b1_beat", 32'({b_m_tid, b_m_tdata, b_m_tlast}), 32'(exp_b));
        check("b1_blocks_done", 32'(b_blocks), 32'(b_cnt));
        b_cnt = b_cnt + 4'd1;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no end of test, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    ap_rst_n   = 1'b0;
    b_rst_n    = 1'b0;
    b_tvalid   = '0;
    b_tdata    = {8'hA3, 8'h00, 8'h00, 8'hA0};
    b_m_tready = 1'b1;

    // Reset values with a lane requesting.
    load(0, 8'hEE, 4);
    repeat (2) @(negedge ap_clk); #1;
    check("rst_tvalid", 32'(m_tvalid), 32'd0);
    check("rst_tready", 32'(s_tready), 32'd0);
    check("rst_tid", 32'(m_tid), 32'd0);
    check("rst_tdata", 32'(m_tdata), 32'd0);
    check("rst_tlast", 32'(m_tlast), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_blocks", 32'(blocks_done), 32'd0);

    // Single lane 2 block.
    do_reset();
    load(2, 8'h10, 8);
    exp_blk(2, 8'h10, 8);
    @(negedge ap_clk); #1;
    check("lat_tvalid_low", 32'(m_tvalid), 32'd0);
    check("lat_busy_low", 32'(busy), 32'd0);
    @(negedge ap_clk); #1;
    check("lat_tvalid_high", 32'(m_tvalid), 32'd1);
    check("lat_tid", 32'(m_tid), 32'd2);
    check("lat_busy_high", 32'(busy), 32'd1);
    repeat (8) @(negedge ap_clk); #1;
    check("t1_busy_after", 32'(busy), 32'd0);
    check("t1_blocks", 32'(blocks_done), 32'd1);
    check("t1_sb_empty", 32'(sb.size()), 32'd0);

    // All lanes valid: order 0,1,2,3,0 with one idle cycle between blocks.
    do_reset();
    load(0, 8'h00, 16);
    load(1, 8'h20, 8);
    load(2, 8'h30, 8);
    load(3, 8'h40, 8);
    exp_blk(0, 8'h00, 8);
    exp_blk(1, 8'h20, 8);
    exp_blk(2, 8'h30, 8);
    exp_blk(3, 8'h40, 8);
    exp_blk(0, 8'h08, 8);
    wait_valid(10);
    begin
      int cnt;
      cnt = 0;
      while (blocks_done != 16'd5 && cnt < 200) begin
        @(negedge ap_clk); #1;
        cnt++;
      end
      check("t2_cycles", 32'(cnt), 32'd44);
    end
    check("t2_blocks", 32'(blocks_done), 32'd5);
    check("t2_sb_empty", 32'(sb.size()), 32'd0);

    // Lane 1 stalls mid-block while lane 3 waits.
    do_reset();
    load(1, 8'h40, 8);
    load(3, 8'h60, 8);
    exp_blk(1, 8'h40, 8);
    exp_blk(3, 8'h60, 8);
    wait_valid(10);
    check("t3_first_tid", 32'(m_tid), 32'd1);
    repeat (2) @(negedge ap_clk);
    lane_en[1] = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(negedge ap_clk); #1;
      check("t3_stall_tvalid", 32'(m_tvalid), 32'd0);
      check("t3_stall_tid", 32'(m_tid), 32'd1);
      check("t3_stall_busy", 32'(busy), 32'd1);
      check("t3_lane3_tready", 32'(s_tready[3]), 32'd0);
    end
    lane_en[1] = 1'b1;
    wait_blocks(2, 100);
    check("t3_sb_empty", 32'(sb.size()), 32'd0);

    // Random downstream backpressure, lanes 0 and 1.
    do_reset();
    rnd_rdy = 1'b1;
    load(0, 8'h80, 16);
    load(1, 8'h90, 16);
    exp_blk(0, 8'h80, 8);
    exp_blk(1, 8'h90, 8);
    exp_blk(0, 8'h88, 8);
    exp_blk(1, 8'h98, 8);
    wait_blocks(4, 600);
    rnd_rdy = 1'b0;
    check("t4_sb_empty", 32'(sb.size()), 32'd0);

    // Asynchronous reset while beat 5 of lane 2 is presented.
    do_reset();
    load(2, 8'h50, 8);
    exp_blk(2, 8'h50, 4);
    wait_valid(10);
    repeat (3) @(negedge ap_clk);
    @(posedge ap_clk); #3;
    ap_rst_n = 1'b0;
    #1;
    check("t5_tvalid", 32'(m_tvalid), 32'd0);
    check("t5_tready", 32'(s_tready), 32'd0);
    check("t5_tid", 32'(m_tid), 32'd0);
    check("t5_tdata", 32'(m_tdata), 32'd0);
    check("t5_tlast", 32'(m_tlast), 32'd0);
    check("t5_busy", 32'(busy), 32'd0);
    check("t5_blocks", 32'(blocks_done), 32'd0);
    for (int i = 0; i < N; i++) lq[i].delete();
    load(1, 8'h70, 8);
    load(3, 8'h30, 8);
    exp_blk(1, 8'h70, 8);
    exp_blk(3, 8'h30, 8);
    repeat (2) @(negedge ap_clk);
    ap_rst_n = 1'b1;
    wait_valid(10);
    check("t5_first_tid", 32'(m_tid), 32'd1);
    wait_blocks(2, 100);
    check("t5_sb_empty", 32'(sb.size()), 32'd0);

    // BDIM=1 build: lanes 0 and 3 alternate, blocks_done wraps 15 -> 0.
    for (int k = 0; k < 18; k++) begin
      logic [1:0] t;
      logic [7:0] d;
      t = (k % 2 == 0) ? 2'd0 : 2'd3;
      d = (k % 2 == 0) ? 8'hA0 : 8'hA3;
      sb_b.push_back({t, d, 1'b1});
    end
    @(negedge ap_clk);
    b_rst_n  = 1'b1;
    b_tvalid = 4'b1001;
    for (int k = 0; k < 100; k++) begin
      @(negedge ap_clk); #1;
      if (sb_b.size() == 0) break;
    end
    @(posedge ap_clk); #1;
    b_tvalid = '0;
    @(negedge ap_clk); #1;
    check("b1_final_blocks", 32'(b_blocks), 32'd2);
    check("b1_sb_empty", 32'(sb_b.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
